// File: rtl/iq_capture_pkg.sv
// iq_capture_pkg: shared types and helpers for the I/Q capture buffer.
// Holds the capture FSM state encoding, default widths and the |x| >= level compare.
package iq_capture_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    // Magnitude is formed one bit wider than the sample so that the most
    // negative input does not wrap when negated.
    function automatic logic abs_ge(input logic signed [31:0] x,
                                    input logic        [31:0] lvl);
        logic signed [32:0] xe;
        logic        [32:0] mag;
        xe  = {x[31], x};
        mag = xe[32] ? 33'(-xe) : 33'(xe);
        return mag >= {1'b0, lvl};
    endfunction

endpackage

// File: rtl/iq_capture_buffer_if.sv
// iq_capture_buffer_if: sample input, control, CSR read and status bundle.
// master = SoC/filter side (drives samples, arm/abort, rd_addr); slave = buffer.
interface iq_capture_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 10,
    parameter int CW = AW + 1
);
    logic signed [DW-1:0]   in_x;
    logic signed [DW-1:0]   in_y;
    logic                   in_valid;
    logic                   arm;
    logic                   abort;
    logic        [CW-1:0]   cap_len;
    logic        [DW-1:0]   trig_level;
    logic        [AW-1:0]   rd_addr;
    logic        [2*DW-1:0] rd_data;
    logic                   busy;
    logic                   done;
    logic        [CW-1:0]   wr_count;

    modport master (
        output in_x, in_y, in_valid, arm, abort, cap_len, trig_level, rd_addr,
        input  rd_data, busy, done, wr_count
    );

    modport slave (
        input  in_x, in_y, in_valid, arm, abort, cap_len, trig_level, rd_addr,
        output rd_data, busy, done, wr_count
    );
endinterface

// File: rtl/iq_capture_ram.sv
// iq_capture_ram: simple dual-port RAM, one write port, one registered read port.
// Ports: clk, rst_n (clears read register only), we/waddr/wdata, raddr -> rdata (1-cycle, read-first).
module iq_capture_ram #(
    parameter int W  = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/iq_capture_buffer.sv
// iq_capture_buffer: captures a burst of decimated X/Y pairs into RAM for CPU readout.
// Ports: sys_clk, rst_n (sync, active-low), bus (iq_capture_buffer_if.slave). Option: IQ_CAPTURE_LEVEL_TRIG_EN.
module iq_capture_buffer
    import iq_capture_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = AW + 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    iq_capture_buffer_if.slave   bus
);
    localparam logic [CW-1:0] FULL = CW'(2**AW);

    cap_state_e      state, state_nx;
    logic [CW-1:0]   len_q, len_clamp, wr_count;
    logic [AW-1:0]   wr_ptr;
    logic [2*DW-1:0] rd_data;
    logic            start, we, last, hit;

    always_comb begin
        len_clamp = bus.cap_len;
        if (bus.cap_len == '0) begin
            len_clamp = CW'(1);
        end else if (bus.cap_len > FULL) begin
            len_clamp = FULL;
        end
    end

`ifdef IQ_CAPTURE_LEVEL_TRIG_EN
    assign hit = bus.in_valid &&
                 abs_ge(32'(bus.in_x), 32'(bus.trig_level));
`else
    logic unused_trig;
    assign unused_trig = ^bus.trig_level;
    assign hit         = 1'b0;
`endif

    assign start = (state == IDLE || state == DONE) && bus.arm && !bus.abort;
    // The triggering sample is stored on the ARMED->CAPTURE edge itself.
    assign we    = !bus.abort &&
                   ((state == CAPTURE && bus.in_valid) ||
                    (state == ARMED && hit));
    assign last  = (wr_count + CW'(1)) == len_q;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (bus.arm) state_nx = ARMED;
`ifdef IQ_CAPTURE_LEVEL_TRIG_EN
                ARMED:      if (we) state_nx = last ? DONE : CAPTURE;
`else
                ARMED:      state_nx = CAPTURE;
`endif
                CAPTURE:    if (we && last) state_nx = DONE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy     = (state == ARMED) || (state == CAPTURE);
        bus.done     = (state == DONE);
        bus.wr_count = wr_count;
        bus.rd_data  = rd_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            len_q    <= '0;
            wr_count <= '0;
            wr_ptr   <= '0;
        end else if (start) begin
            len_q    <= len_clamp;
            wr_count <= '0;
            wr_ptr   <= '0;
        end else if (we) begin
            wr_count <= wr_count + CW'(1);
            wr_ptr   <= wr_ptr + AW'(1);
        end
    end

    iq_capture_ram #(
        .W  (2*DW),
        .AW (AW)
    ) u_ram (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({bus.in_x, bus.in_y}),
        .raddr (bus.rd_addr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_iq_capture_buffer.sv
// tb_iq_capture_buffer: directed self-checking bench for iq_capture_buffer (AW=4).
// Level-trigger vectors are compiled in only with IQ_CAPTURE_LEVEL_TRIG_EN.
module tb_iq_capture_buffer;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = AW + 1;

    logic sys_clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    logic [2*DW-1:0] d;

    iq_capture_buffer_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    iq_capture_buffer #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pair(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic strobe(input int x, input int y);
        bus.in_x     = x[15:0];
        bus.in_y     = y[15:0];
        bus.in_valid = 1'b1;
        cyc(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic arm_len(input int l);
        bus.cap_len = l[CW-1:0];
        bus.arm     = 1'b1;
        cyc(1);
        bus.arm     = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] q);
        bus.rd_addr = a[AW-1:0];
        cyc(1);
        q = bus.rd_data;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_x       = '0;
        bus.in_y       = '0;
        bus.in_valid   = 1'b0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.cap_len    = '0;
        bus.trig_level = '0;
        bus.rd_addr    = '0;
        cyc(3);
        chk("init_busy", 32'(bus.busy), 0);
        chk("init_done", 32'(bus.done), 0);
        chk("init_cnt", 32'(bus.wr_count), 0);
        chk("init_rd", bus.rd_data, 0);
        rst_n = 1'b1;
        cyc(1);

        // reset in the middle of a capture
        arm_len(8);
        cyc(1);
        strobe(1, 1);
        strobe(2, 2);
        chk("pre_rst_cnt", 32'(bus.wr_count), 2);
        rst_n = 1'b0;
        cyc(3);
        chk("rst_rd", bus.rd_data, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cnt", 32'(bus.wr_count), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_done", 32'(bus.done), 0);
        chk("post_rst_cnt", 32'(bus.wr_count), 0);

        // basic 8-sample capture, strobe every 4th cycle
        arm_len(8);
        chk("arm_busy", 32'(bus.busy), 1);
        chk("arm_cnt", 32'(bus.wr_count), 0);
        cyc(1);
        for (int k = 1; k <= 8; k++) begin
            strobe(k, -k);
            if (k == 7) begin
                chk("b7_done", 32'(bus.done), 0);
                chk("b7_cnt", 32'(bus.wr_count), 7);
            end
            if (k == 8) begin
                chk("b8_done", 32'(bus.done), 1);
                chk("b8_busy", 32'(bus.busy), 0);
                chk("b8_cnt", 32'(bus.wr_count), 8);
            end
            cyc(3);
        end
        strobe(9, -9);
        chk("b9_cnt", 32'(bus.wr_count), 8);
        chk("b9_done", 32'(bus.done), 1);
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            chk($sformatf("b_rd%0d", a), d, pair(a + 1, -(a + 1)));
        end

        // full depth, no overwrite
        arm_len(16);
        cyc(1);
        for (int k = 0; k < 16; k++) begin
            strobe(100 + k, k);
            if (k == 14) chk("f15_done", 32'(bus.done), 0);
        end
        chk("f_done", 32'(bus.done), 1);
        chk("f_cnt", 32'(bus.wr_count), 16);
        for (int a = 0; a < 16; a++) begin
            rd(a, d);
            chk($sformatf("f_rd%0d", a), d, pair(100 + a, a));
        end

        // cap_len=0 clamps to one sample
        arm_len(0);
        cyc(1);
        strobe(7, 7);
        chk("z_done", 32'(bus.done), 1);
        chk("z_cnt", 32'(bus.wr_count), 1);
        strobe(8, 8);
        chk("z_cnt2", 32'(bus.wr_count), 1);
        rd(0, d);
        chk("z_rd0", d, pair(7, 7));
        rd(1, d);
        chk("z_rd1", d, pair(101, 1));

        // cap_len above depth clamps to full depth
        arm_len(20);
        cyc(1);
        for (int k = 0; k < 16; k++) strobe(200 + k, k);
        chk("o_done", 32'(bus.done), 1);
        chk("o_cnt", 32'(bus.wr_count), 16);
        strobe(250, 0);
        chk("o_cnt2", 32'(bus.wr_count), 16);

        // abort + arm + in_valid in the same cycle during capture
        arm_len(8);
        cyc(1);
        for (int k = 0; k < 3; k++) strobe(k, k);
        chk("a_pre_cnt", 32'(bus.wr_count), 3);
        bus.abort    = 1'b1;
        bus.arm      = 1'b1;
        bus.in_x     = 16'sd55;
        bus.in_y     = 16'sd55;
        bus.in_valid = 1'b1;
        cyc(1);
        bus.abort    = 1'b0;
        bus.arm      = 1'b0;
        bus.in_valid = 1'b0;
        chk("a_busy", 32'(bus.busy), 0);
        chk("a_done", 32'(bus.done), 0);
        chk("a_cnt", 32'(bus.wr_count), 3);
        rd(3, d);
        chk("a_rd3", d, pair(203, 3));
        arm_len(2);
        chk("a_rearm_cnt", 32'(bus.wr_count), 0);
        chk("a_rearm_busy", 32'(bus.busy), 1);
        cyc(1);
        strobe(1, 1);
        strobe(2, 2);
        chk("a_re_done", 32'(bus.done), 1);
        chk("a_re_cnt", 32'(bus.wr_count), 2);

        // arm during capture is ignored
        arm_len(4);
        cyc(1);
        strobe(1, 1);
        strobe(2, 2);
        arm_len(12);
        chk("i_cnt", 32'(bus.wr_count), 2);
        chk("i_busy", 32'(bus.busy), 1);
        strobe(3, 3);
        chk("i3_done", 32'(bus.done), 0);
        strobe(4, 4);
        chk("i4_done", 32'(bus.done), 1);
        chk("i4_cnt", 32'(bus.wr_count), 4);

`ifdef IQ_CAPTURE_LEVEL_TRIG_EN
        bus.trig_level = 16'd100;
        arm_len(4);
        cyc(1);
        strobe(50, 1);
        chk("t50_cnt", 32'(bus.wr_count), 0);
        strobe(-99, 2);
        chk("t99_cnt", 32'(bus.wr_count), 0);
        chk("t99_busy", 32'(bus.busy), 1);
        strobe(-100, 3);
        chk("t100_cnt", 32'(bus.wr_count), 1);
        strobe(30, 4);
        chk("t30_cnt", 32'(bus.wr_count), 2);
        rd(0, d);
        chk("t_rd0", d, pair(-100, 3));
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        bus.trig_level = 16'd32767;
        arm_len(1);
        cyc(1);
        strobe(32766, 6);
        chk("tmax_cnt", 32'(bus.wr_count), 0);
        strobe(-32768, 5);
        chk("tmin_done", 32'(bus.done), 1);
        chk("tmin_cnt", 32'(bus.wr_count), 1);
        rd(0, d);
        chk("tmin_rd0", d, pair(-32768, 5));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
